// File: rtl/osd_rom_arbiter_if.sv
// OSD font ROM arbiter bus: requester side, grant and ROM read-back.
// master drives requests and ROM data, slave is the arbiter.
interface osd_rom_arbiter_if #(
  parameter int PORT_NUM = 10,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16
);
  logic [PORT_NUM-1:0]        i_req;
  logic [PORT_NUM*ADDR_W-1:0] i_addr;
  logic [PORT_NUM-1:0]        o_gnt;
  logic [ADDR_W-1:0]          o_rom_addr;
  logic [DATA_W-1:0]          i_rom_data;
  logic [DATA_W-1:0]          o_rd_data;
  logic [PORT_NUM-1:0]        o_rd_valid;

  modport master (
    output i_req, i_addr, i_rom_data,
    input  o_gnt, o_rom_addr, o_rd_data, o_rd_valid
  );

  modport slave (
    input  i_req, i_addr, i_rom_data,
    output o_gnt, o_rom_addr, o_rd_data, o_rd_valid
  );
endinterface

// File: rtl/osd_rom_arbiter.sv
// Round-robin arbiter sharing one OSD font ROM between char_display stages.
// Optional OSD_ARB_STATS_EN adds conflict and max-wait statistics.
module osd_rom_arbiter #(
  parameter int PORT_NUM = 10,
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 16,
  parameter int ROM_LAT  = 1
) (
  input  logic pclk,
  input  logic rst_n,
  osd_rom_arbiter_if.slave bus
`ifdef OSD_ARB_STATS_EN
  ,
  input  logic        i_stats_clr,
  output logic [15:0] o_conflict_cnt,
  output logic [7:0]  o_max_wait
`endif
);

  localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int DEPTH = ROM_LAT + 1;

  logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [PORT_NUM-1:0] gnt_oh;
  logic [ADDR_W-1:0]   addr_arr [PORT_NUM];

  logic [DEPTH-1:0]    tag_vld_q, tag_vld_d;
  logic [PTR_W-1:0]    tag_idx_q [DEPTH];
  logic [PTR_W-1:0]    tag_idx_d [DEPTH];
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [PORT_NUM-1:0] rd_valid_q, rd_valid_d;

  // unpack the flat per-port address bus
  always_comb begin
    for (int k = 0; k < PORT_NUM; k++) begin
      addr_arr[k] = bus.i_addr[k*ADDR_W +: ADDR_W];
    end
  end

  // first requester at or after rr_ptr wins, wrapping at the top port
  always_comb begin
    int p;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    p = 0;
    for (int i = 0; i < PORT_NUM; i++) begin
      p = int'(rr_ptr_q) + i;
      if (p >= PORT_NUM) p = p - PORT_NUM;
      if (!gnt_vld && bus.i_req[PTR_W'(p)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PTR_W'(p);
      end
    end
    gnt_oh = '0;
    if (gnt_vld && rst_n) gnt_oh[gnt_idx] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      if (gnt_idx == PTR_W'(PORT_NUM - 1)) rr_ptr_d = '0;
      else rr_ptr_d = gnt_idx + 1'b1;
    end
  end

  // tag pipeline tracks the granted port through the ROM latency
  always_comb begin
    tag_vld_d[0] = gnt_vld;
    tag_idx_d[0] = gnt_idx;
    for (int i = 1; i < DEPTH; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
    rom_addr_d = gnt_vld ? addr_arr[gnt_idx] : rom_addr_q;
    rd_data_d  = tag_vld_q[DEPTH-1] ? bus.i_rom_data : rd_data_q;
    rd_valid_d = '0;
    if (tag_vld_q[DEPTH-1]) rd_valid_d[tag_idx_q[DEPTH-1]] = 1'b1;
  end

  // arbitration and read pipeline state
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      tag_vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) tag_idx_q[i] <= '0;
      rom_addr_q <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_vld_q  <= tag_vld_d;
      for (int i = 0; i < DEPTH; i++) tag_idx_q[i] <= tag_idx_d[i];
      rom_addr_q <= rom_addr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.o_gnt      = gnt_oh;
  assign bus.o_rom_addr = rom_addr_q;
  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;

`ifdef OSD_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;
  logic [7:0]  max_wait_q, max_wait_d;
  logic [7:0]  wait_q [PORT_NUM];
  logic [7:0]  wait_d [PORT_NUM];

  // per-port wait since request rise or last grant, plus the stat counters
  always_comb begin
    for (int k = 0; k < PORT_NUM; k++) begin
      if (!bus.i_req[k] || gnt_oh[k]) wait_d[k] = '0;
      else if (wait_q[k] != 8'hFF) wait_d[k] = wait_q[k] + 8'd1;
      else wait_d[k] = wait_q[k];
    end
    conflict_d = conflict_q;
    max_wait_d = max_wait_q;
    if (i_stats_clr) begin
      conflict_d = '0;
      max_wait_d = '0;
    end else begin
      if ($countones(bus.i_req) >= 2 && conflict_q != 16'hFFFF)
        conflict_d = conflict_q + 16'd1;
      if (gnt_vld && wait_q[gnt_idx] > max_wait_q)
        max_wait_d = wait_q[gnt_idx];
    end
  end

  // statistics state
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_q <= '0;
      max_wait_q <= '0;
      for (int k = 0; k < PORT_NUM; k++) wait_q[k] <= '0;
    end else begin
      conflict_q <= conflict_d;
      max_wait_q <= max_wait_d;
      for (int k = 0; k < PORT_NUM; k++) wait_q[k] <= wait_d[k];
    end
  end

  assign o_conflict_cnt = conflict_q;
  assign o_max_wait     = max_wait_q;
`endif

endmodule
